// File: rtl/fetch_pkg.sv
// Shared constants and the default-width queue entry layout for the
// instruction fetch front-end.
package fetch_pkg;

  localparam int PC_STEP     = 4;
  localparam int PC_LSB_MASK = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous in-order FIFO with flush. Output is the registered head
// entry; it reads as zero while the FIFO is empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Upstream credit accounting must never let a push land on a full queue.
  push_not_full_a: assert property (@(posedge clk) disable iff (!rst)
    (push && !flush && !pop) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the PC, issues sequential word reads under a credit
// limit, buffers responses in order and flushes on branch redirect.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic              started_q, started_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]     occupancy;
  logic [CW:0]       credit_used;
  logic              fifo_empty;
  logic              push, pop, resp_drop;
  logic [ADDR_W-1:0] redirect_target;
  entry_t            push_entry, head_entry;

  assign redirect_target = redirect_pc & ~ADDR_W'(PC_LSB_MASK);
  assign credit_used     = {1'b0, occupancy} + {1'b0, outstanding_q};

  // started_q keeps imem_req low while in reset and for the first cycle after.
  assign imem_req  = started_q && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign resp_drop = imem_rvalid && (drop_cnt_q != '0);
  assign push      = imem_rvalid && (drop_cnt_q == '0) && !redirect_valid;
  assign if_valid  = !fifo_empty && !redirect_valid;
  assign pop       = if_valid && if_ready;

  assign push_entry = '{instr: imem_rdata, pc: resp_pc_q};
  assign if_instr   = head_entry.instr;
  assign if_pc      = head_entry.pc;

  always_comb begin
    started_d     = 1'b1;
    outstanding_d = outstanding_q + CW'(imem_req) - CW'(imem_rvalid);
    drop_cnt_d    = drop_cnt_q - CW'(resp_drop);
    fetch_pc_d    = imem_req ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    resp_pc_d     = push ? resp_pc_q + ADDR_W'(PC_STEP) : resp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      // The in-flight count already includes responses still marked for
      // dropping, so every surviving in-flight response becomes stale.
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q     <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      started_q     <= started_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head_entry),
    .empty (fifo_empty),
    .count (occupancy)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed phases push expected PCs,
// a monitor pops and compares on every accepted output.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_rvalid2;
  logic [31:0] imem_rdata2;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [31:0] if_pc2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          due_v;
  int          first_req_cyc = -1;
  int          first_valid_cyc = -1;
  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] e;
  logic [31:0] e2;

  instr_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_rvalid    (imem_rvalid2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_valid       (if_valid2),
    .if_instr       (if_instr2),
    .if_pc          (if_pc2),
    .if_ready       (1'b1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] logAddr(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Memory model: in-order responses, data = ~addr, latency mem_lat cycles.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      if (imem_req) begin
        due_v = cyc + mem_lat;
        if (mq.size() > 0 && due_v <= mq[mq.size()-1].due) due_v = mq[mq.size()-1].due + 1;
        mq.push_back('{addr: imem_addr, due: due_v});
        if (req_log.size() == 0) first_req_cyc = cyc;
        req_log.push_back(imem_addr);
      end
    end
  end

  // Latency-1 memory for the wrap-around instance.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_rvalid2 <= 1'b0;
      imem_rdata2  <= '0;
    end else begin
      imem_rvalid2 <= imem_req2;
      imem_rdata2  <= ~imem_addr2;
    end
  end

  // Consumer accepts only while the scoreboard expects more outputs.
  always @(posedge clk) begin
    #2;
    if_ready = (exp_q.size() > 0);
  end

  // Monitor: compare each accepted output against the scoreboard head.
  always @(negedge clk) begin
    if (rst && if_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (if_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output actual_pc=0x%08h required=none", if_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("if_pc", if_pc, e);
          checkOutput("if_instr", if_instr, ~e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && if_valid2 && exp2_q.size() > 0) begin
      e2 = exp2_q.pop_front();
      checkOutput("wrap_if_pc", if_pc2, e2);
      checkOutput("wrap_if_instr", if_instr2, ~e2);
    end
  end

  task automatic waitExpSize(input int target, input int maxc, input string name);
    int n;
    n = 0;
    while (exp_q.size() != target && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != target) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=%0d required=%0d", name, exp_q.size(), target);
    end
  endtask

  task automatic waitReqCount(input int target, input int maxc, input string name);
    int n;
    n = 0;
    while (req_log.size() < target && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (req_log.size() < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=%0d required=%0d", name, req_log.size(), target);
    end
  endtask

  task automatic applyStimulus_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    req_log.delete();
    exp_q.delete();
    first_req_cyc = -1;
    first_valid_cyc = -1;
  endtask

  task automatic applyStimulus_release();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    exp2_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_imem_req", 32'(imem_req), 32'h0);
    checkOutput("reset_imem_addr", imem_addr, 32'h0);
    checkOutput("reset_if_valid", 32'(if_valid), 32'h0);
    checkOutput("reset_if_instr", if_instr, 32'h0);
    checkOutput("reset_if_pc", if_pc, 32'h0);
    checkOutput("reset_wrap_addr", imem_addr2, 32'hFFFF_FFF8);

    // Sequential fetch, latency 1, consumer always ready.
    mem_lat = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    applyStimulus_release();
    waitExpSize(0, 60, "seq_drain");
    checkOutput("seq_req0", logAddr(0), 32'h0);
    checkOutput("seq_req1", logAddr(1), 32'h4);
    checkOutput("seq_req2", logAddr(2), 32'h8);
    checkOutput("seq_valid_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);

    // Let the queue fill, then assert reset between clock edges.
    repeat (8) @(posedge clk);
    #1;
    checkOutput("full_if_valid", 32'(if_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_imem_req", 32'(imem_req), 32'h0);
    checkOutput("async_if_valid", 32'(if_valid), 32'h0);
    checkOutput("async_if_pc", if_pc, 32'h0);
    checkOutput("async_if_instr", if_instr, 32'h0);
    checkOutput("async_imem_addr", imem_addr, 32'h0);

    // Stall: consumer not ready, exactly DEPTH requests then hold.
    applyStimulus_reset();
    mem_lat = 1;
    applyStimulus_release();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("stall_req_count", 32'(req_log.size()), 32'd4);
    checkOutput("stall_req3", logAddr(3), 32'hC);
    checkOutput("stall_imem_req", 32'(imem_req), 32'h0);
    checkOutput("stall_fetch_pc", imem_addr, 32'h10);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    waitExpSize(0, 60, "stall_drain");
    checkOutput("stall_resume_addr", logAddr(4), 32'h10);

    // Redirect with three requests in flight, latency 3, unaligned target.
    applyStimulus_reset();
    mem_lat = 3;
    applyStimulus_release();
    waitReqCount(3, 20, "lat3_reqs");
    redirect_pc = 32'h103;
    redirect_valid = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    #1;
    checkOutput("redir_imem_req", 32'(imem_req), 32'h0);
    checkOutput("redir_if_valid", 32'(if_valid), 32'h0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    waitExpSize(0, 60, "lat3_drain");
    checkOutput("redir_first_req", logAddr(3), 32'h100);

    // Redirect colliding with a response and a ready consumer.
    applyStimulus_reset();
    mem_lat = 1;
    exp_q = '{32'h0, 32'h4, 32'h200, 32'h204};
    applyStimulus_release();
    waitExpSize(2, 20, "collide_pre");
    redirect_pc = 32'h200;
    redirect_valid = 1'b1;
    #1;
    checkOutput("collide_if_valid", 32'(if_valid), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("collide_rvalid", 32'(imem_rvalid), 32'h1);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    waitExpSize(0, 40, "collide_drain");

    // Back-to-back redirects: second target wins, drops accumulate.
    applyStimulus_reset();
    mem_lat = 3;
    applyStimulus_release();
    waitReqCount(2, 20, "b2b_reqs");
    redirect_pc = 32'h300;
    redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    redirect_pc = 32'h400;
    exp_q.push_back(32'h400);
    exp_q.push_back(32'h404);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    waitExpSize(0, 60, "b2b_drain");
    checkOutput("b2b_first_req", logAddr(2), 32'h400);

    checkOutput("wrap_seq_left", 32'(exp2_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
